// File: rtl/stream_fifo_if.sv
// Stream handshake bundle between a producer/consumer and the FIFO.
// The write side is in_*, the read side is out_*.
interface stream_fifo_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    // Environment side: supplies write words and accepts read words
    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  out_data,
        input  out_valid,
        output out_ready
    );

    // FIFO side
    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output out_data,
        output out_valid,
        input  out_ready
    );
endinterface

// File: rtl/stream_fifo.sv
// First-word fall-through stream FIFO with arbitrary (non power-of-two) depth,
// synchronous flush, occupancy count and almost-full flag. Status outputs are
// decoded purely from the registered count, so there is no combinational
// path from in_valid/out_ready to any handshake output.
module stream_fifo #(
    parameter int WIDTH       = 4,
    parameter int DEPTH       = 5,
    parameter int AFULL_LEVEL = DEPTH - 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    stream_fifo_if.slave               fifo_if,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       almost_full
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic push;
    logic pop;

    // Status decode from registered occupancy only
    assign fifo_if.in_ready  = (count_q != CW'(DEPTH));
    assign fifo_if.out_valid = (count_q != '0);
    assign fifo_if.out_data  = mem[rd_ptr_q];
    assign almost_full       = (count_q >= CW'(AFULL_LEVEL));
    assign count             = count_q;

    // Next-state for pointers and occupancy; flush wins over any transfer
    always_comb begin
        push     = fifo_if.in_valid && fifo_if.in_ready && !clear;
        pop      = fifo_if.out_valid && fifo_if.out_ready && !clear;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    // Control state with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array, deliberately without reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= fifo_if.in_data;
        end
    end

endmodule

// File: tb/tb_stream_fifo.sv
// Directed self-checking bench for stream_fifo (WIDTH=4, DEPTH=5, AFULL_LEVEL=4).
module tb_stream_fifo;

    logic       clk;
    logic       rst_n;
    logic       clear;
    logic [2:0] count;
    logic       almost_full;

    int errors;
    int checks;

    stream_fifo_if #(.WIDTH(4)) bus ();

    stream_fifo #(
        .WIDTH(4),
        .DEPTH(5),
        .AFULL_LEVEL(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .clear(clear),
        .fifo_if(bus.slave),
        .count(count),
        .almost_full(almost_full)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs, advance past the rising edge
    task automatic applyStimulus(input logic inValid, input logic [3:0] inData,
                                 input logic outReady, input logic clr);
        bus.in_valid  = inValid;
        bus.in_data   = inData;
        bus.out_ready = outReady;
        clear         = clr;
        @(posedge clk);
        #1;
    endtask

    // Directed test sequence
    initial begin
        errors        = 0;
        checks        = 0;
        rst_n         = 1'b0;
        clear         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;

        // Reset state
        #2;
        checkOutput("rst_count", 32'(count), 0);
        checkOutput("rst_out_valid", 32'(bus.out_valid), 0);
        checkOutput("rst_in_ready", 32'(bus.in_ready), 1);
        checkOutput("rst_afull", 32'(almost_full), 0);
        #6;
        rst_n = 1'b1;

        // Fill with 1..5, consumer stalled
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(1'b1, 4'(i), 1'b0, 1'b0);
            checkOutput("fill_count", 32'(count), 32'(i));
            checkOutput("fill_afull", 32'(almost_full), (i >= 4) ? 1 : 0);
            checkOutput("fill_in_ready", 32'(bus.in_ready), (i < 5) ? 1 : 0);
            checkOutput("fill_head", 32'(bus.out_data), 1);
        end
        applyStimulus(1'b1, 4'd6, 1'b0, 1'b0);
        checkOutput("refuse_count", 32'(count), 5);
        checkOutput("refuse_head", 32'(bus.out_data), 1);

        // Drain in order
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            checkOutput("drain_valid", 32'(bus.out_valid), 1);
            checkOutput("drain_data", 32'(bus.out_data), 32'(i));
            applyStimulus(1'b0, 4'd0, 1'b1, 1'b0);
        end
        checkOutput("drain_out_valid", 32'(bus.out_valid), 0);
        checkOutput("drain_count", 32'(count), 0);

        // Wrap: prime with 7,8 then 12 push/pop pairs pushing 9,10,...
        applyStimulus(1'b1, 4'd7, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'd8, 1'b0, 1'b0);
        checkOutput("wrap_prime_count", 32'(count), 2);
        for (int k = 0; k < 12; k++) begin
            checkOutput("wrap_head", 32'(bus.out_data), 32'((7 + k) & 15));
            applyStimulus(1'b1, 4'((9 + k) & 15), 1'b1, 1'b0);
            checkOutput("wrap_count", 32'(count), 2);
        end
        checkOutput("wrap_tail0", 32'(bus.out_data), 3);
        applyStimulus(1'b0, 4'd0, 1'b1, 1'b0);
        checkOutput("wrap_tail1", 32'(bus.out_data), 4);
        applyStimulus(1'b0, 4'd0, 1'b1, 1'b0);
        checkOutput("wrap_empty", 32'(count), 0);

        // Full with simultaneous pop: only the pop happens
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(1'b1, 4'(i), 1'b0, 1'b0);
        end
        applyStimulus(1'b1, 4'd9, 1'b1, 1'b0);
        checkOutput("fullpop_count", 32'(count), 4);
        checkOutput("fullpop_head", 32'(bus.out_data), 2);
        applyStimulus(1'b1, 4'd9, 1'b0, 1'b0);
        checkOutput("fullpop_push_count", 32'(count), 5);
        checkOutput("fullpop_in_ready", 32'(bus.in_ready), 0);

        // Clear at count=3 overrides push and pop
        applyStimulus(1'b0, 4'd0, 1'b1, 1'b0);
        applyStimulus(1'b0, 4'd0, 1'b1, 1'b0);
        checkOutput("preclear_count", 32'(count), 3);
        checkOutput("preclear_head", 32'(bus.out_data), 4);
        applyStimulus(1'b1, 4'd12, 1'b1, 1'b1);
        checkOutput("clear_count", 32'(count), 0);
        checkOutput("clear_out_valid", 32'(bus.out_valid), 0);
        checkOutput("clear_in_ready", 32'(bus.in_ready), 1);
        applyStimulus(1'b0, 4'd0, 1'b1, 1'b0);
        checkOutput("postclear_count", 32'(count), 0);
        checkOutput("postclear_valid", 32'(bus.out_valid), 0);

        // Asynchronous reset mid-cycle at count=4
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1'b1, 4'(i), 1'b0, 1'b0);
        end
        bus.in_valid = 1'b0;
        checkOutput("prereset_count", 32'(count), 4);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("areset_count", 32'(count), 0);
        checkOutput("areset_out_valid", 32'(bus.out_valid), 0);
        checkOutput("areset_in_ready", 32'(bus.in_ready), 1);
        checkOutput("areset_afull", 32'(almost_full), 0);
        #2;
        rst_n = 1'b1;
        applyStimulus(1'b1, 4'hA, 1'b0, 1'b0);
        checkOutput("postreset_valid", 32'(bus.out_valid), 1);
        checkOutput("postreset_data", 32'(bus.out_data), 32'hA);
        checkOutput("postreset_count", 32'(count), 1);

        // Push and pop together at count=1: new word becomes head
        applyStimulus(1'b1, 4'hB, 1'b1, 1'b0);
        checkOutput("pp1_count", 32'(count), 1);
        checkOutput("pp1_head", 32'(bus.out_data), 32'hB);
        applyStimulus(1'b0, 4'd0, 1'b1, 1'b0);
        checkOutput("final_count", 32'(count), 0);
        checkOutput("final_valid", 32'(bus.out_valid), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
